// File: rtl/mem_access_ctrl_pkg.sv
// State encoding, byte-lane constants and opcode helpers for the
// data-memory access sequencer.
`include "op_def.sv"

package mem_access_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  function automatic logic is_store(input logic [5:0] op);
    return (op == `OP_SB) || (op == `OP_SH) || (op == `OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, response and data-memory signals of the access sequencer;
// master is the surrounding core/memory, slave is the sequencer.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane logic: byte enables, lane-replicated store data,
// sign/zero-extended load data and alignment/opcode error.
`include "op_def.sv"

module mem_lane_unit
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  byte_be;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    byte_sel = rdata[7:0];
    byte_be  = BE_BYTE0;
    case (addr)
      2'd1: begin byte_sel = rdata[15:8];  byte_be = BE_BYTE1; end
      2'd2: begin byte_sel = rdata[23:16]; byte_be = BE_BYTE2; end
      2'd3: begin byte_sel = rdata[31:24]; byte_be = BE_BYTE3; end
      default: ;
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    lane_wdata = 32'h0;
    ext_rdata  = 32'h0;
    err        = 1'b0;
    case (op)
      `OP_LB:  begin be = byte_be; ext_rdata = {{24{byte_sel[7]}}, byte_sel}; end
      `OP_LBU: begin be = byte_be; ext_rdata = {24'h0, byte_sel}; end
      `OP_SB:  begin be = byte_be; lane_wdata = {4{wdata[7:0]}}; end
      `OP_LH: begin
        be        = addr[1] ? BE_HALF1 : BE_HALF0;
        err       = addr[0];
        ext_rdata = {{16{half_sel[15]}}, half_sel};
      end
      `OP_LHU: begin
        be        = addr[1] ? BE_HALF1 : BE_HALF0;
        err       = addr[0];
        ext_rdata = {16'h0, half_sel};
      end
      `OP_SH: begin
        be         = addr[1] ? BE_HALF1 : BE_HALF0;
        err        = addr[0];
        lane_wdata = {2{wdata[15:0]}};
      end
      `OP_LW:  begin be = BE_WORD; err = (addr != 2'd0); ext_rdata = rdata; end
      `OP_SW:  begin be = BE_WORD; err = (addr != 2'd0); lane_wdata = wdata; end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/op_def.sv
// MIPS load/store primary opcodes shared across the core.
`ifndef OP_DEF_SV
`define OP_DEF_SV
`define OP_LB  6'h20
`define OP_LH  6'h21
`define OP_LW  6'h23
`define OP_LBU 6'h24
`define OP_LHU 6'h25
`define OP_SB  6'h28
`define OP_SH  6'h29
`define OP_SW  6'h2B
`endif

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer: latches one request, drives the
// variable-latency data memory until ack, then holds the response.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus
);

  logic [1:0]        state;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [5:0]  lane_op;
  logic [1:0]  lane_addr;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_err;
  logic        idle;
  logic        issue;
  logic        unused_addr;

  assign idle  = (state == S_IDLE);
  assign issue = (state == S_ISSUE);

  // One lane unit serves both the request (in IDLE) and the read capture (in ISSUE).
  assign lane_op   = idle ? bus.req_op        : op_q;
  assign lane_addr = idle ? bus.req_addr[1:0] : addr_q[1:0];

  mem_lane_unit u_lane (
    .op         (lane_op),
    .addr       (lane_addr),
    .wdata      (bus.req_wdata),
    .rdata      (bus.mem_rdata),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .ext_rdata  (lane_rdata),
    .err        (lane_err)
  );

  assign unused_addr = ^bus.req_addr[31:ADDR_W];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous and clears all of them.
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= 6'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr[ADDR_W-1:0];
            wdata_q <= lane_wdata;
            be_q    <= lane_be;
            err_q   <= lane_err;
            rdata_q <= 32'h0;
            state   <= lane_err ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_ack) begin
            rdata_q <= lane_rdata;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = idle;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = bus.resp_valid ? rdata_q : 32'h0;
  assign bus.resp_err   = bus.resp_valid & err_q;

  // Memory side is forced to zero outside ISSUE.
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & is_store(op_q);
  assign bus.mem_be    = issue ? be_q : 4'h0;
  assign bus.mem_addr  = issue ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata = issue ? wdata_q : 32'h0;

endmodule
